// File: rtl/id_imm_stage_pkg.sv
// Shared decode constants, skid-buffer state encoding and the instruction
// classifier for the ID immediate stage.
package id_imm_stage_pkg;

  localparam logic [1:0] EXT_OP_NONE  = 2'b00;
  localparam logic [1:0] EXT_OP_IMM12 = 2'b01;
  localparam logic [1:0] EXT_OP_IMM16 = 2'b10;
  localparam logic [1:0] EXT_OP_IMM28 = 2'b11;

  localparam logic [9:0] OP10_ADDI_W = 10'b0000001010;
  localparam logic [9:0] OP10_SLTI   = 10'b0000001000;
  localparam logic [9:0] OP10_SLTUI  = 10'b0000001001;
  localparam logic [9:0] OP10_LD_B   = 10'b0010100000;
  localparam logic [9:0] OP10_LD_H   = 10'b0010100001;
  localparam logic [9:0] OP10_LD_W   = 10'b0010100010;
  localparam logic [9:0] OP10_LD_BU  = 10'b0010101000;
  localparam logic [9:0] OP10_LD_HU  = 10'b0010101001;
  localparam logic [9:0] OP10_ST_B   = 10'b0010100100;
  localparam logic [9:0] OP10_ST_H   = 10'b0010100101;
  localparam logic [9:0] OP10_ST_W   = 10'b0010100110;
  localparam logic [9:0] OP10_ANDI   = 10'b0000001101;
  localparam logic [9:0] OP10_ORI    = 10'b0000001110;
  localparam logic [9:0] OP10_XORI   = 10'b0000001111;

  localparam logic [5:0] OP6_JIRL = 6'b010011;
  localparam logic [5:0] OP6_BEQ  = 6'b010110;
  localparam logic [5:0] OP6_BNE  = 6'b010111;
  localparam logic [5:0] OP6_BLT  = 6'b011000;
  localparam logic [5:0] OP6_BGE  = 6'b011001;
  localparam logic [5:0] OP6_BLTU = 6'b011010;
  localparam logic [5:0] OP6_BGEU = 6'b011011;
  localparam logic [5:0] OP6_B    = 6'b010100;
  localparam logic [5:0] OP6_BL   = 6'b010101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic [1:0] ext_op;
    logic       is_zext;
  } dec_t;

  // Everything an EX consumer needs besides the PC, held per skid slot.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [1:0]  ext_op;
    logic        is_zext;
  } payload_t;

  localparam payload_t PAYLOAD_RESET = '{
    inst:    32'h0000_0000,
    imm:     32'h0000_0000,
    ext_op:  EXT_OP_NONE,
    is_zext: 1'b0
  };

  // 10-bit major opcodes never start with a branch prefix, so the 6-bit
  // lookup only runs when the 10-bit table misses.
  function automatic dec_t decode_inst(input logic [31:0] inst);
    dec_t d;
    d.ext_op  = EXT_OP_NONE;
    d.is_zext = 1'b0;
    case (inst[31:22])
      OP10_ADDI_W, OP10_SLTI, OP10_SLTUI,
      OP10_LD_B, OP10_LD_H, OP10_LD_W, OP10_LD_BU, OP10_LD_HU,
      OP10_ST_B, OP10_ST_H, OP10_ST_W: begin
        d.ext_op = EXT_OP_IMM12;
      end
      OP10_ANDI, OP10_ORI, OP10_XORI: begin
        d.ext_op  = EXT_OP_IMM12;
        d.is_zext = 1'b1;
      end
      default: begin
        case (inst[31:26])
          OP6_JIRL, OP6_BEQ, OP6_BNE, OP6_BLT,
          OP6_BGE, OP6_BLTU, OP6_BGEU: d.ext_op = EXT_OP_IMM16;
          OP6_B, OP6_BL:               d.ext_op = EXT_OP_IMM28;
          default:                     d.ext_op = EXT_OP_NONE;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_imm_stage_ext.sv
// Immediate-extension unit: builds the 32-bit immediate from the low 26
// instruction bits according to the decoded op.
module id_imm_stage_ext
  import id_imm_stage_pkg::*;
(
  input  logic [25:0] imm_field_i,
  input  logic [1:0]  ext_op_i,
  input  logic        is_zext_i,
  output logic [31:0] imm_o
);

  // Branch offsets are word offsets, hence the two appended zero bits.
  always_comb begin
    imm_o = 32'h0000_0000;
    case (ext_op_i)
      EXT_OP_IMM12: begin
        if (is_zext_i) begin
          imm_o = {20'h0_0000, imm_field_i[21:10]};
        end else begin
          imm_o = {{20{imm_field_i[21]}}, imm_field_i[21:10]};
        end
      end
      EXT_OP_IMM16: imm_o = {{14{imm_field_i[25]}}, imm_field_i[25:10], 2'b00};
      EXT_OP_IMM28: imm_o = {{4{imm_field_i[9]}}, imm_field_i[9:0],
                             imm_field_i[25:10], 2'b00};
      default:      imm_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/id_imm_stage.sv
// ID-stage immediate controller: classifies the fetched instruction, extends
// its immediate and holds the result in a 2-entry skid buffer towards EX.
module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_imm,
  output logic [1:0]      out_ext_op,
  output logic            out_is_zext
);

  skid_state_e     state_q, state_d;
  logic            in_ready_q;
  payload_t        m_pay_q, s_pay_q;
  logic [PC_W-1:0] m_pc_q, s_pc_q;

  dec_t            dec;
  logic [31:0]     imm;
  payload_t        in_pay;
  logic            acc, pop;
  logic            load_m_in, load_s_in, load_m_s;

  assign dec = decode_inst(in_inst);

  id_imm_stage_ext u_ext (
    .imm_field_i (in_inst[25:0]),
    .ext_op_i    (dec.ext_op),
    .is_zext_i   (dec.is_zext),
    .imm_o       (imm)
  );

  assign in_pay = '{inst: in_inst, imm: imm, ext_op: dec.ext_op, is_zext: dec.is_zext};

  assign acc = in_valid & in_ready_q;
  assign pop = (state_q != ST_EMPTY) & out_ready;

  // State register; in_ready is registered from the next state so EX
  // back-pressure never reaches IF through a combinational path.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  // Next-state logic; flush overrides everything, a same-cycle pop is
  // simply consumed.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) state_d = ST_ONE;
          else     state_d = ST_EMPTY;
        end
        ST_ONE: begin
          if (acc && !pop)      state_d = ST_TWO;
          else if (!acc && pop) state_d = ST_EMPTY;
          else                  state_d = ST_ONE;
        end
        ST_TWO: begin
          if (pop) state_d = ST_ONE;
          else     state_d = ST_TWO;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Datapath load strobes derived from the current state and handshakes.
  always_comb begin
    load_m_in = 1'b0;
    load_s_in = 1'b0;
    load_m_s  = 1'b0;
    if (flush) begin
      load_m_in = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: load_m_in = acc;
        ST_ONE: begin
          load_m_in = acc & pop;
          load_s_in = acc & ~pop;
        end
        ST_TWO:   load_m_s = pop;
        default:  load_m_in = 1'b0;
      endcase
    end
  end

  // Main slot: drives out_* and is cleared by reset so an empty stage
  // presents a clean, all-zero NONE instruction.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      m_pay_q <= PAYLOAD_RESET;
      m_pc_q  <= '0;
    end else if (load_m_in) begin
      m_pay_q <= in_pay;
      m_pc_q  <= in_pc;
    end else if (load_m_s) begin
      m_pay_q <= s_pay_q;
      m_pc_q  <= s_pc_q;
    end else begin
      m_pay_q <= m_pay_q;
      m_pc_q  <= m_pc_q;
    end
  end

  // Skid slot: only meaningful in ST_TWO, so it carries no reset.
  always_ff @(posedge cpu_clk) begin
    if (load_s_in) begin
      s_pay_q <= in_pay;
      s_pc_q  <= in_pc;
    end else begin
      s_pay_q <= s_pay_q;
      s_pc_q  <= s_pc_q;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_inst    = m_pay_q.inst;
  assign out_pc      = m_pc_q;
  assign out_imm     = m_pay_q.imm;
  assign out_ext_op  = m_pay_q.ext_op;
  assign out_is_zext = m_pay_q.is_zext;

endmodule

// File: tb/tb_id_imm_stage.sv
// Self-checking bench for id_imm_stage: directed scenarios followed by a
// randomized run, all checked against a queue-based reference model.
module tb_id_imm_stage;

  localparam int PC_W = 32;

  localparam logic [9:0] OP10_TAB [14] = '{
    10'b0000001010, 10'b0000001000, 10'b0000001001, 10'b0010100000,
    10'b0010100001, 10'b0010100010, 10'b0010101000, 10'b0010101001,
    10'b0010100100, 10'b0010100101, 10'b0010100110, 10'b0000001101,
    10'b0000001110, 10'b0000001111};
  localparam logic [5:0] OP6_TAB [9] = '{
    6'b010011, 6'b010110, 6'b010111, 6'b011000, 6'b011001,
    6'b011010, 6'b011011, 6'b010100, 6'b010101};

  logic            cpu_clk = 1'b0;
  logic            cpu_rst, in_valid, in_ready, flush;
  logic            out_valid, out_ready, out_is_zext;
  logic [31:0]     in_inst, out_inst, out_imm;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [1:0]      out_ext_op;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  op;
    logic        zext;
  } ent_t;

  ent_t mq[$];

  id_imm_stage #(.PC_W(PC_W)) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_ext_op  (out_ext_op),
    .out_is_zext (out_is_zext)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Expected classification and immediate, computed with signed arithmetic.
  function automatic ent_t ref_entry(input logic [31:0] inst, input logic [31:0] pc);
    ent_t e;
    int   v;
    e.inst = inst; e.pc = pc; e.imm = 32'd0; e.op = 2'd0; e.zext = 1'b0;
    if (inst[31:22] inside {10'b0000001010, 10'b0000001000, 10'b0000001001,
                            10'b0010100000, 10'b0010100001, 10'b0010100010,
                            10'b0010101000, 10'b0010101001, 10'b0010100100,
                            10'b0010100101, 10'b0010100110}) begin
      v = int'({20'd0, inst[21:10]});
      if (v >= 2048) v = v - 4096;
      e.imm = 32'(v); e.op = 2'd1;
    end else if (inst[31:22] inside {10'b0000001101, 10'b0000001110, 10'b0000001111}) begin
      e.imm = 32'(int'({20'd0, inst[21:10]})); e.op = 2'd1; e.zext = 1'b1;
    end else if (inst[31:26] inside {6'b010011, 6'b010110, 6'b010111, 6'b011000,
                                     6'b011001, 6'b011010, 6'b011011}) begin
      v = int'({16'd0, inst[25:10]});
      if (v >= 32768) v = v - 65536;
      e.imm = 32'(v * 4); e.op = 2'd2;
    end else if (inst[31:26] inside {6'b010100, 6'b010101}) begin
      v = int'({6'd0, inst[9:0], inst[25:10]});
      if (v >= 33554432) v = v - 67108864;
      e.imm = 32'(v * 4); e.op = 2'd3;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0, 1:    r[31:22] = OP10_TAB[$urandom_range(0, 13)];
      2, 3:    r[31:26] = OP6_TAB[$urandom_range(0, 8)];
      default: r = r;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(mq.size() < 2));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk({tag, ".out_inst"}, 64'(out_inst), 64'(mq[0].inst));
      chk({tag, ".out_pc"}, 64'(out_pc), 64'(mq[0].pc));
      chk({tag, ".out_imm"}, 64'(out_imm), 64'(mq[0].imm));
      chk({tag, ".out_ext_op"}, 64'(out_ext_op), 64'(mq[0].op));
      chk({tag, ".out_is_zext"}, 64'(out_is_zext), 64'(mq[0].zext));
    end
  endtask

  // Advance one clock, update the model with the inputs seen at that edge.
  task automatic cycle(input string tag);
    bit has_space;
    @(posedge cpu_clk);
    #1;
    has_space = (mq.size() < 2);
    if (flush) begin
      mq.delete();
    end else begin
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (in_valid && has_space) mq.push_back(ref_entry(in_inst, in_pc));
    end
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] inst);
    in_valid = v;
    in_inst  = inst;
    in_pc    = in_pc + 32'd4;
  endtask

  initial begin
    cpu_rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'h1000;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check_all("reset");
    chk("reset.out_inst", 64'(out_inst), 64'd0);
    chk("reset.out_pc", 64'(out_pc), 64'd0);
    chk("reset.out_imm", 64'(out_imm), 64'd0);
    chk("reset.out_ext_op", 64'(out_ext_op), 64'd0);
    chk("reset.out_is_zext", 64'(out_is_zext), 64'd0);
    cpu_rst = 1'b0;

    // Fill both slots, then reset between edges.
    drive(1'b1, 32'h02BF_FC01); cycle("pre_a");
    drive(1'b1, 32'h03BF_FC01); cycle("pre_b");
    chk("pre.in_ready_two", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    #2 cpu_rst = 1'b1;
    #1;
    mq.delete();
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    chk("midrst.out_ext_op", 64'(out_ext_op), 64'd0);
    #2 cpu_rst = 1'b0;

    out_ready = 1'b1;
    drive(1'b1, 32'h02BF_FC01); cycle("addi");
    chk("addi.imm", 64'(out_imm), 64'hFFFF_FFFF);
    chk("addi.op", 64'(out_ext_op), 64'd1);
    chk("addi.zext", 64'(out_is_zext), 64'd0);
    drive(1'b1, 32'h03BF_FC01); cycle("ori");
    chk("ori.imm", 64'(out_imm), 64'h0000_0FFF);
    chk("ori.zext", 64'(out_is_zext), 64'd1);
    drive(1'b1, 32'h5BFF_FC00); cycle("beq");
    chk("beq.imm", 64'(out_imm), 64'hFFFF_FFFC);
    chk("beq.op", 64'(out_ext_op), 64'd2);
    drive(1'b1, 32'h5000_0400); cycle("b");
    chk("b.imm", 64'(out_imm), 64'h0000_0004);
    chk("b.op", 64'(out_ext_op), 64'd3);
    drive(1'b0, 32'd0); cycle("drain");

    // Back-pressure: A, B fill the buffer, C waits at IF.
    out_ready = 1'b0;
    drive(1'b1, 32'h0280_0401); cycle("bp_a");
    drive(1'b1, 32'h0280_0802); cycle("bp_b");
    chk("bp.in_ready_after_b", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h0280_0C03); cycle("bp_c_hold1");
    cycle("bp_c_hold2");
    chk("bp.hold_a", 64'(out_inst), 64'h0280_0401);
    out_ready = 1'b1;
    cycle("bp_pop_a");
    chk("bp.order_b", 64'(out_inst), 64'h0280_0802);
    cycle("bp_pop_b");
    chk("bp.order_c", 64'(out_inst), 64'h0280_0C03);
    in_valid = 1'b0;
    cycle("bp_pop_c");
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Flush while full with D offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h0280_1004); cycle("fl_a");
    drive(1'b1, 32'h0280_1405); cycle("fl_b");
    flush = 1'b1;
    drive(1'b1, 32'h0280_1806); cycle("fl_d");
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle("fl_after");

    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      drive($urandom_range(0, 3) != 0, rand_inst());
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
